// File: rtl/rnic_exdes_write_rx_generator.sv
// RDMA WRITE-ONLY packet generator for the RNIC example design receive path.
// On a start pulse it emits NUM_PKTS packets on an AXI4-Stream master. Each packet
// is one header beat carrying the PSN and the WRITE ONLY opcode, followed by
// PAYLOAD_BEATS all-ones beats. Packets are separated by IPG_CYCLES idle cycles.
//
// Ports:
//   core_clk, core_aresetn   clock and asynchronous active-low reset
//   start_i                  single-cycle pulse that begins a run (ignored while busy)
//   m_axis_*                 AXI4-Stream master (tdata/tkeep/tvalid/tlast/tready)
//   write_pkt_psn            PSN of the packet currently being sent
//   pkt_sent_cnt             packets completed in the current run (saturates at 31)
//   busy_o                   high while a run is in progress
//   rdma_write_test_done_o   sticky run-complete flag, cleared by start_i or reset
module rnic_exdes_write_rx_generator #(
    parameter int unsigned C_AXIS_DATA_WIDTH = 512,
    parameter int unsigned NUM_PKTS          = 16,
    parameter int unsigned PAYLOAD_BEATS     = 4,
    parameter logic [23:0] START_PSN         = 24'h000000,
    parameter int unsigned IPG_CYCLES        = 2
) (
    input  logic                           core_clk,
    input  logic                           core_aresetn,
    input  logic                           start_i,
    output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready,
    output logic [23:0]                    write_pkt_psn,
    output logic [4:0]                     pkt_sent_cnt,
    output logic                           busy_o,
    output logic                           rdma_write_test_done_o
);

    // Header field positions within the 512-bit beat
    localparam int unsigned PsnLsb    = 408;
    localparam int unsigned OpcodeLsb = 336;
    localparam logic [7:0]  OpWriteOnly = 8'h0A;

    typedef enum logic [2:0] {StIdle, StHdr, StPayload, StGap, StDone} state_e;

    state_e      state_q, state_d;
    logic [23:0] psn_q, psn_d;
    logic [7:0]  beat_idx_q, beat_idx_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [4:0]  pkt_cnt_q, pkt_cnt_d;
    logic        done_q, done_d;

    logic        beat_xfer;
    logic        last_beat;
    logic        last_pkt;
    logic        load_run;

    assign m_axis_tvalid = (state_q == StHdr) || (state_q == StPayload);
    assign busy_o        = m_axis_tvalid || (state_q == StGap);
    assign beat_xfer     = m_axis_tvalid && m_axis_tready;
    assign last_beat     = beat_idx_q == 8'(PAYLOAD_BEATS - 1);
    assign last_pkt      = pkt_cnt_q == 5'(NUM_PKTS - 1);
    assign load_run      = start_i && !busy_o;

    assign m_axis_tlast           = (state_q == StPayload) && last_beat;
    assign m_axis_tkeep           = m_axis_tvalid ? '1 : '0;
    assign write_pkt_psn          = psn_q;
    assign pkt_sent_cnt           = pkt_cnt_q;
    assign rdma_write_test_done_o = done_q;

    // Beat contents depend only on registered state, so they hold while stalled
    always_comb begin
        m_axis_tdata = '0;
        if (state_q == StHdr) begin
            m_axis_tdata[PsnLsb +: 24]   = psn_q;
            m_axis_tdata[OpcodeLsb +: 8] = OpWriteOnly;
        end else if (state_q == StPayload) begin
            m_axis_tdata = '1;
        end
    end

    always_comb begin
        state_d    = state_q;
        psn_d      = psn_q;
        beat_idx_d = beat_idx_q;
        gap_cnt_d  = gap_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        done_d     = done_q;

        unique case (state_q)
            StIdle: ;
            StHdr: begin
                if (beat_xfer) begin
                    beat_idx_d = '0;
                    state_d    = StPayload;
                end
            end
            StPayload: begin
                if (beat_xfer) begin
                    beat_idx_d = beat_idx_q + 8'd1;
                    if (last_beat) begin
                        pkt_cnt_d = (pkt_cnt_q == 5'd31) ? pkt_cnt_q : pkt_cnt_q + 5'd1;
                        psn_d     = psn_q + 24'd1;
                        if (last_pkt) begin
                            state_d = StDone;
                        end else if (IPG_CYCLES == 0) begin
                            state_d = StHdr;
                        end else begin
                            gap_cnt_d = '0;
                            state_d   = StGap;
                        end
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == 4'(IPG_CYCLES - 1)) begin
                    state_d = StHdr;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A start seen while not busy (IDLE or DONE) begins a fresh run
        if (load_run) begin
            psn_d     = START_PSN;
            pkt_cnt_d = '0;
            done_d    = 1'b0;
            state_d   = StHdr;
        end
    end

    always_ff @(posedge core_clk or negedge core_aresetn) begin
        if (!core_aresetn) begin
            state_q    <= StIdle;
            psn_q      <= '0;
            beat_idx_q <= '0;
            gap_cnt_q  <= '0;
            pkt_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            psn_q      <= psn_d;
            beat_idx_q <= beat_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            done_q     <= done_d;
        end
    end

endmodule
